// File: rtl/hc_csr_regfile.sv
// HardCloud MMIO CSR register file.
// Holds N buffer descriptors (64b address + 32b size), the DSM base address
// and the run-control FSM. Reads respond one cycle after the request.
// Descriptor and DSM writes are refused while the accelerator is running.

// One buffer descriptor: address/size storage plus "written since clear" bits.
module hc_csr_desc (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        addr_we,
    input  logic        size_we,
    input  logic        clr_seen,
    input  logic [63:0] wr_data,
    output logic [63:0] address,
    output logic [31:0] size,
    output logic        valid
);
    logic addr_seen;
    logic size_seen;

    // Storage survives a soft clear; only the seen bits are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            address   <= '0;
            size      <= '0;
            addr_seen <= 1'b0;
            size_seen <= 1'b0;
        end else begin
            if (addr_we) address <= wr_data;
            if (size_we) size    <= wr_data[31:0];
            if (clr_seen) begin
                addr_seen <= 1'b0;
                size_seen <= 1'b0;
            end else begin
                if (addr_we) addr_seen <= 1'b1;
                if (size_we) size_seen <= 1'b1;
            end
        end
    end

    assign valid = addr_seen & size_seen;
endmodule

module hc_csr_regfile #(
    parameter int          TX_CHANNELS = 1,
    parameter int          RX_CHANNELS = 1,
    parameter logic [15:0] BUF_BASE    = 16'h120,
    parameter logic [15:0] DSM_ADDR    = 16'h110,
    parameter logic [15:0] CTL_ADDR    = 16'h118,
    parameter int          TID_W       = 9,
    localparam int         N           = TX_CHANNELS + RX_CHANNELS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mmio_wr_valid,
    input  logic              mmio_rd_valid,
    input  logic [15:0]       mmio_addr,
    input  logic [TID_W-1:0]  mmio_tid,
    input  logic [63:0]       mmio_wr_data,
    output logic              rd_rsp_valid,
    output logic [TID_W-1:0]  rd_rsp_tid,
    output logic [63:0]       rd_rsp_data,
    output logic [N*64-1:0]   buf_address,
    output logic [N*32-1:0]   buf_size,
    output logic [N-1:0]      buf_valid,
    output logic [63:0]       dsm_base,
    output logic              soft_rst_n,
    output logic              start_pulse,
    output logic              running,
    output logic              err_flag
);
    // Dword addresses of the decoded registers.
    localparam logic [15:0] BASE_DW = BUF_BASE >> 2;
    localparam logic [15:0] DSM_DW  = DSM_ADDR >> 2;
    localparam logic [15:0] CTL_DW  = CTL_ADDR >> 2;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_IDLE  = 2'd1,
        S_RUN   = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                 state;
    logic [N-1:0][63:0]     desc_addr;
    logic [N-1:0][31:0]     desc_size;
    logic [N-1:0]           addr_hit;
    logic [N-1:0]           size_hit;
    logic                   dsm_hit;
    logic                   ctl_hit;
    logic                   wr_even;
    logic                   reg_wr;
    logic                   reg_wr_ok;
    logic                   reg_wr_bad;
    logic                   ctl_wr;
    logic                   clr_seen;
    logic [63:0]            rd_data_nxt;

    // Address decode; odd (32b) accesses never hit anything.
    always_comb begin
        addr_hit = '0;
        size_hit = '0;
        for (int i = 0; i < N; i++) begin
            addr_hit[i] = ~mmio_addr[0] && (mmio_addr == BASE_DW + 16'(4 * i));
            size_hit[i] = ~mmio_addr[0] && (mmio_addr == BASE_DW + 16'(4 * i + 2));
        end
    end

    assign dsm_hit    = ~mmio_addr[0] && (mmio_addr == DSM_DW);
    assign ctl_hit    = ~mmio_addr[0] && (mmio_addr == CTL_DW);
    assign wr_even    = mmio_wr_valid & ~mmio_addr[0];
    assign reg_wr     = wr_even & ((|addr_hit) | (|size_hit) | dsm_hit);
    assign reg_wr_ok  = reg_wr & (state != S_RUN);
    assign reg_wr_bad = reg_wr & (state == S_RUN);
    assign ctl_wr     = wr_even & ctl_hit;
    assign clr_seen   = ctl_wr & (mmio_wr_data[31:0] == 32'h0);

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_desc
            hc_csr_desc u_desc (
                .clk      (clk),
                .reset_n  (reset_n),
                .addr_we  (reg_wr_ok & addr_hit[g]),
                .size_we  (reg_wr_ok & size_hit[g]),
                .clr_seen (clr_seen),
                .wr_data  (mmio_wr_data),
                .address  (desc_addr[g]),
                .size     (desc_size[g]),
                .valid    (buf_valid[g])
            );
        end
    endgenerate

    assign buf_address = desc_addr;
    assign buf_size    = desc_size;

    // DSM base register, protected the same way as the descriptors.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dsm_base <= '0;
        else if (reg_wr_ok && dsm_hit) dsm_base <= mmio_wr_data;
    end

    // Run-control FSM with sticky error flag and start pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_RESET;
            err_flag    <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            if (reg_wr_bad) err_flag <= 1'b1;
            if (ctl_wr) begin
                case (mmio_wr_data[31:0])
                    32'h0: begin
                        state    <= S_RESET;
                        err_flag <= 1'b0;
                    end
                    32'h1: begin
                        if (state == S_RESET || state == S_STOP) state <= S_IDLE;
                        else err_flag <= 1'b1;
                    end
                    32'h3: begin
                        if (state == S_IDLE && &buf_valid) begin
                            state       <= S_RUN;
                            start_pulse <= 1'b1;
                        end else begin
                            err_flag <= 1'b1;
                        end
                    end
                    32'h7: begin
                        if (state == S_RUN) state <= S_STOP;
                        else err_flag <= 1'b1;
                    end
                    default: err_flag <= 1'b1;
                endcase
            end
        end
    end

    assign running    = (state == S_RUN);
    assign soft_rst_n = (state != S_RESET);

    // Read mux over current register contents (same-cycle writes not visible).
    always_comb begin
        rd_data_nxt = '0;
        if (dsm_hit) rd_data_nxt = dsm_base;
        if (ctl_hit) rd_data_nxt = {61'b0, err_flag, state};
        for (int i = 0; i < N; i++) begin
            if (addr_hit[i]) rd_data_nxt = desc_addr[i];
            if (size_hit[i]) rd_data_nxt = {32'b0, desc_size[i]};
        end
    end

    // Registered read response; every read responds, unmapped ones with 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_rsp_valid <= 1'b0;
            rd_rsp_tid   <= '0;
            rd_rsp_data  <= '0;
        end else begin
            rd_rsp_valid <= mmio_rd_valid;
            if (mmio_rd_valid) begin
                rd_rsp_tid  <= mmio_tid;
                rd_rsp_data <= rd_data_nxt;
            end
        end
    end
endmodule
